dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory end of the processor DMEM interface: the responder for the processor's load/store signals.
- Storage is a word array with lane-level writes. Stores commit on the clock edge. Loads are combinational, because the single-cycle core consumes read data in the same cycle.
- After reset, an init FSM clears the array before any access is serviced.
- Misaligned accesses are blocked, latched and counted for debug and verification.

Parameters:
- ADDR_BITS, 10, word-index width. Depth is 2**ADDR_BITS words.
- INIT_VALUE, 32'h0, value written to every word during init.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr_to_mem  input  [0:31]  byte address. Bit 0 is the MSB.
- write_enable_to_mem  input  1  store request this cycle.
- byte_to_mem  input  1  byte-size access.
- half_word_to_mem  input  1  halfword-size access.
- sign_extend_to_mem  input  1  sign-extend sub-word loads.
- data_to_mem  input  [0:31]  store data. Sub-word stores use the low bits, i.e. [24:31] or [16:31].
- data_from_mem  output  [0:31]  load data.
- mem_ready  output  1  init sweep complete; accesses are serviced.
- misalign_err  output  1  sticky misalignment flag.
- err_addr  output  [0:31]  address of the first misaligned access.
- store_count  output  [0:15]  committed stores, saturating.

Behaviour:
- Reset (reset=0, asynchronous) drives all of the following immediately:
  - FSM goes to INIT and the init pointer is set to 0.
  - mem_ready=0, misalign_err=0, err_addr=0, store_count=0.
  - Array contents are not touched by reset itself.
- FSM states: INIT and RUN.
  - INIT: each cycle writes INIT_VALUE to word[ptr], then ptr+1. After the cycle that writes the last word, the FSM moves to RUN; total 2**ADDR_BITS cycles.
  - RUN: mem_ready=1. Only reset leaves RUN.
  - Reset mid-INIT restarts the sweep at word 0.
- Addressing:
  - Word index is addr[30-ADDR_BITS:29]. Upper bits are ignored, so addresses alias.
  - Lane is addr[30:31], big-endian: lane 0 = bits [0:7], lane 3 = bits [24:31].
- Size: byte_to_mem takes priority over half_word_to_mem. If neither is set, the access is a word.
- Misalignment rules:
  - Halfword is misaligned when addr[31]=1.
  - Word is misaligned when addr[30:31]!=0.
  - Byte is never misaligned.
- Store in RUN, aligned: at the clock edge only the selected lanes are written.
  - Byte: data[24:31] goes to lane addr[30:31].
  - Halfword: data[16:31] goes to lanes {addr[30],0} and {addr[30],1}.
  - store_count increments and saturates at 16'hFFFF.
- Load (write_enable_to_mem=0) in RUN, aligned: combinational.
  - Byte result lands in [24:31]; halfword result lands in [16:31].
  - Upper bits are zero, or copies of the sub-word MSB when sign_extend_to_mem=1.
  - sign_extend_to_mem is ignored for word loads.
- Misaligned access in RUN:
  - Store is suppressed and store_count is unchanged.
  - data_from_mem=0.
  - At the edge, misalign_err is set. err_addr is captured only if misalign_err was already 0, so it holds the first fault.
  - The flag clears only on reset.
- During INIT: stores are ignored, data_from_mem=0, and no error is logged.
- Read-during-store, same cycle: data_from_mem shows the pre-write contents. The new data is visible the following cycle.
- data_from_mem is 0 whenever write_enable_to_mem=1.

Test Plan:
- Init and timing: release reset and count cycles → mem_ready rises exactly 1024 cycles later (ADDR_BITS=10). Load word at 0x0000_0FFC → 0x0000_0000.
- Byte store and lane: store word 0x1122_3344 at 0x10, then store byte 0x000000AB at 0x12 → word load at 0x10 returns 0x1122_AB44. store_count=2.
- Sign extension: byte load at 0x12 with sign_extend=1 → 0xFFFF_FFAB; with sign_extend=0 → 0x0000_00AB. Halfword load at 0x10 with sign_extend=1 → 0x0000_1122.
- Misalignment: word store 0xDEADBEEF at 0x21, then halfword load at 0x33 →
  - misalign_err=1 and err_addr=0x0000_0021.
  - Word at 0x20 is unchanged (0).
  - Halfword load returns 0.
  - store_count is unchanged.
- Aliasing: store 0x55 as a word at 0x0000_1004 (beyond 4 KiB) → word load at 0x0000_0004 returns 0x0000_0055.
- Reset mid-INIT: pulse reset low at init cycle 500 → mem_ready rises 1024 cycles after the release, and all outputs read 0 during the pulse.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the processor DMEM port. Holds a word array with
// byte-lane writes. Stores commit on the rising edge. Loads are combinational
// so the single-cycle core can consume read data in the same cycle. After
// reset an init sweep clears every word before any access is serviced.
// Misaligned accesses are blocked, and the first faulting address is latched.
//
// Ports (big-endian bit numbering, bit 0 = MSB):
//   clock               in   system clock, rising edge
//   reset               in   asynchronous active-low reset
//   addr_to_mem         in   [0:31] byte address
//   write_enable_to_mem in   store request this cycle
//   byte_to_mem         in   byte-size access (wins over halfword)
//   half_word_to_mem    in   halfword-size access
//   sign_extend_to_mem  in   sign-extend sub-word loads
//   data_to_mem         in   [0:31] store data, sub-words taken from low bits
//   data_from_mem       out  [0:31] load data
//   mem_ready           out  init sweep done, accesses serviced
//   misalign_err        out  sticky misalignment flag
//   err_addr            out  [0:31] address of first misaligned access
//   store_count         out  [0:15] committed stores, saturating
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | sweeping INIT_VALUE into word[ptr]; accesses ignored
// ST_RUN  | array live; loads/stores serviced, misalignment logged
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int          ADDR_BITS  = 10,
   parameter logic [31:0] INIT_VALUE = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [0:31] addr_to_mem,
   input  logic        write_enable_to_mem,
   input  logic        byte_to_mem,
   input  logic        half_word_to_mem,
   input  logic        sign_extend_to_mem,
   input  logic [0:31] data_to_mem,
   output logic [0:31] data_from_mem,
   output logic        mem_ready,
   output logic        misalign_err,
   output logic [0:31] err_addr,
   output logic [0:15] store_count
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic                 misalign_err_q, misalign_err_d;
   logic [0:31]          err_addr_q, err_addr_d;
   logic [0:15]          store_count_q, store_count_d;

   logic [0:31] mem_q [DEPTH];

   // FSM outputs
   logic run;
   logic init_wr;

   // Access decode
   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           lane;
   logic                 is_byte, is_half, is_word;
   logic                 misaligned;
   logic                 access_ok;
   logic                 store_commit;
   logic                 load_en;
   logic [0:3]           lane_we;
   logic [0:31]          wr_data;
   logic [0:31]          rd_word;
   logic [0:7]           byte_val;
   logic [0:15]          half_val;
   logic [0:31]          load_data;

   // Upper address bits alias onto the array and are intentionally dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_to_mem[0:29-ADDR_BITS];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (ptr_q == {ADDR_BITS{1'b1}}) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // FSM: outputs
   always_comb begin
      run     = 1'b0;
      init_wr = 1'b0;
      case (state_q)
         ST_INIT: init_wr = 1'b1;
         ST_RUN:  run     = 1'b1;
         default: begin
            run     = 1'b0;
            init_wr = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------------
   always_comb begin
      word_idx   = addr_to_mem[30-ADDR_BITS:29];
      lane       = addr_to_mem[30:31];
      is_byte    = byte_to_mem;
      is_half    = !byte_to_mem && half_word_to_mem;
      is_word    = !byte_to_mem && !half_word_to_mem;
      misaligned = (is_half && addr_to_mem[31]) ||
                   (is_word && (addr_to_mem[30] || addr_to_mem[31]));
      access_ok    = run && !misaligned;
      store_commit = access_ok && write_enable_to_mem;
      load_en      = access_ok && !write_enable_to_mem;
   end

   // Store lane enables and lane-replicated write data, so each lane always
   // takes its slice of wr_data regardless of access size.
   always_comb begin
      lane_we = 4'b0000;
      wr_data = data_to_mem;
      if (store_commit) begin
         if (is_byte) begin
            lane_we[lane] = 1'b1;
            wr_data       = {4{data_to_mem[24:31]}};
         end else if (is_half) begin
            lane_we[{addr_to_mem[30], 1'b0}] = 1'b1;
            lane_we[{addr_to_mem[30], 1'b1}] = 1'b1;
            wr_data = {2{data_to_mem[16:31]}};
         end else begin
            lane_we = 4'b1111;
            wr_data = data_to_mem;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage: no reset, contents survive reset and are cleared by the sweep
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (init_wr) begin
         mem_q[ptr_q] <= INIT_VALUE;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) mem_q[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Load path: reads pre-write contents in a store cycle, but the output is
   // forced to zero whenever a store is requested anyway.
   // ------------------------------------------------------------------------
   always_comb begin
      rd_word = mem_q[word_idx];
      case (lane)
         2'd0:    byte_val = rd_word[0:7];
         2'd1:    byte_val = rd_word[8:15];
         2'd2:    byte_val = rd_word[16:23];
         default: byte_val = rd_word[24:31];
      endcase
      half_val = addr_to_mem[30] ? rd_word[16:31] : rd_word[0:15];

      if (is_byte) begin
         load_data = {{24{sign_extend_to_mem && byte_val[0]}}, byte_val};
      end else if (is_half) begin
         load_data = {{16{sign_extend_to_mem && half_val[0]}}, half_val};
      end else begin
         load_data = rd_word;
      end

      data_from_mem = load_en ? load_data : 32'h0;
   end

   // ------------------------------------------------------------------------
   // Init pointer, error log, store counter
   // ------------------------------------------------------------------------
   always_comb begin
      ptr_d          = init_wr ? ptr_q + 1'b1 : ptr_q;
      misalign_err_d = misalign_err_q || (run && misaligned);
      err_addr_d     = err_addr_q;
      if (run && misaligned && !misalign_err_q) err_addr_d = addr_to_mem;
      store_count_d  = store_count_q;
      if (store_commit && (store_count_q != 16'hFFFF)) begin
         store_count_d = store_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q          <= '0;
         misalign_err_q <= 1'b0;
         err_addr_q     <= '0;
         store_count_q  <= '0;
      end else begin
         ptr_q          <= ptr_d;
         misalign_err_q <= misalign_err_d;
         err_addr_q     <= err_addr_d;
         store_count_q  <= store_count_d;
      end
   end

   assign mem_ready    = run;
   assign misalign_err = misalign_err_q;
   assign err_addr     = err_addr_q;
   assign store_count  = store_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with ADDR_BITS=10. Inputs change 1 ns
// after the rising edge; outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clock;
   logic        reset;
   logic [0:31] addr_to_mem;
   logic        write_enable_to_mem;
   logic        byte_to_mem;
   logic        half_word_to_mem;
   logic        sign_extend_to_mem;
   logic [0:31] data_to_mem;
   logic [0:31] data_from_mem;
   logic        mem_ready;
   logic        misalign_err;
   logic [0:31] err_addr;
   logic [0:15] store_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cycles;

   dmem_responder #(.ADDR_BITS(10), .INIT_VALUE(32'h0)) u_dut (
      .clock               (clock),
      .reset               (reset),
      .addr_to_mem         (addr_to_mem),
      .write_enable_to_mem (write_enable_to_mem),
      .byte_to_mem         (byte_to_mem),
      .half_word_to_mem    (half_word_to_mem),
      .sign_extend_to_mem  (sign_extend_to_mem),
      .data_to_mem         (data_to_mem),
      .data_from_mem       (data_from_mem),
      .mem_ready           (mem_ready),
      .misalign_err        (misalign_err),
      .err_addr            (err_addr),
      .store_count         (store_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Drive the bus and let combinational outputs settle.
   task automatic drive(input logic [31:0] a, input logic we, input logic b,
                        input logic h, input logic sx, input logic [31:0] d);
      addr_to_mem         = a;
      write_enable_to_mem = we;
      byte_to_mem         = b;
      half_word_to_mem    = h;
      sign_extend_to_mem  = sx;
      data_to_mem         = d;
      #1;
   endtask

   task automatic idle;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   // Count rising edges until mem_ready, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (!mem_ready && n < 3000) begin
         step();
         n++;
      end
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #20;
      chk("rst_ready",   {31'h0, mem_ready},    32'h0);
      chk("rst_err",     {31'h0, misalign_err}, 32'h0);
      chk("rst_erraddr", err_addr,              32'h0);
      chk("rst_count",   {16'h0, store_count},  32'h0);

      // --- init timing -----------------------------------------------------
      @(negedge clock);
      reset = 1'b1;
      wait_ready(cycles);
      chk("init_cycles", cycles, 32'd1024);
      idle();
      drive(32'h0000_0FFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("init_word_ffc", data_from_mem, 32'h0);

      // --- word + byte store -------------------------------------------------
      drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1122_3344);
      chk("store_rd_zero", data_from_mem, 32'h0);
      step();
      drive(32'h12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00AB);
      chk("store_byte_rd_zero", data_from_mem, 32'h0);
      step();
      drive(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("word_after_byte", data_from_mem, 32'h1122_AB44);
      chk("count_2", {16'h0, store_count}, 32'd2);

      // --- sub-word loads ----------------------------------------------------
      drive(32'h12, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("byte_sx", data_from_mem, 32'hFFFF_FFAB);
      drive(32'h12, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("byte_zx", data_from_mem, 32'h0000_00AB);
      drive(32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      chk("half_sx_pos", data_from_mem, 32'h0000_1122);
      drive(32'h13, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("byte_lane3", data_from_mem, 32'h0000_0044);
      drive(32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("byte_priority", data_from_mem, 32'h0000_0011);
      drive(32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("word_ignores_sx", data_from_mem, 32'h1122_AB44);

      // --- misalignment ------------------------------------------------------
      drive(32'h21, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      step();
      chk("mis_err", {31'h0, misalign_err}, 32'h1);
      chk("mis_addr", err_addr, 32'h21);
      drive(32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      chk("mis_half_load", data_from_mem, 32'h0);
      step();
      chk("mis_first_addr", err_addr, 32'h21);
      chk("mis_sticky", {31'h0, misalign_err}, 32'h1);
      drive(32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("mis_word_untouched", data_from_mem, 32'h0);
      chk("mis_count", {16'h0, store_count}, 32'd2);

      // --- aliasing + halfword store -----------------------------------------
      drive(32'h0000_1004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55);
      step();
      drive(32'h16, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_BEEF);
      step();
      drive(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("alias_word", data_from_mem, 32'h0000_0055);
      drive(32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("half_store_word", data_from_mem, 32'h0000_BEEF);
      drive(32'h16, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      chk("half_sx_neg", data_from_mem, 32'hFFFF_BEEF);
      chk("count_4", {16'h0, store_count}, 32'd4);

      // --- reset from RUN, then reset mid-INIT -------------------------------
      @(negedge clock);
      reset = 1'b0;
      drive(32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst2_load_zero", data_from_mem, 32'h0);
      chk("rst2_err", {31'h0, misalign_err}, 32'h0);
      chk("rst2_count", {16'h0, store_count}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      idle();
      for (int i = 0; i < 500; i++) begin
         if (i == 10) drive(32'h41, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
         if (i == 11) begin
            chk("init_no_count", {16'h0, store_count}, 32'h0);
            chk("init_no_err", {31'h0, misalign_err}, 32'h0);
            idle();
         end
         step();
      end
      chk("mid_init_not_ready", {31'h0, mem_ready}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      drive(32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("pulse_ready", {31'h0, mem_ready}, 32'h0);
      chk("pulse_data", data_from_mem, 32'h0);
      chk("pulse_err", {31'h0, misalign_err}, 32'h0);
      chk("pulse_erraddr", err_addr, 32'h0);
      chk("pulse_count", {16'h0, store_count}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      idle();
      wait_ready(cycles);
      chk("reinit_cycles", cycles, 32'd1024);
      drive(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("reinit_cleared", data_from_mem, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
